// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute, memory and
// writeback, drives datapath selects/enables, and traps on illegal opcodes or memory timeouts.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter int RETIRE_W    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         instr,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   input  logic                branch_taken,
   output logic                imem_req,
   output logic                ir_write,
   output logic                pc_write,
   output logic                jump_mux,
   output logic                branch_mux,
   output logic                alu_mux_1,
   output logic                alu2_mux,
   output logic [2:0]          reg_write_mux,
   output logic                reg_write_enable,
   output logic                dmem_read_enable,
   output logic                dmem_write_enable,
   output logic [5:0]          i_format,
   output logic                trap,
   output logic [RETIRE_W-1:0] retired,
   output logic [2:0]          state_dbg
);

   // Handshake: imem_req/dmem_*_enable stay high until the matching ready is
   // sampled high on a rising edge; that cycle completes the transfer.

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      OP_ILL, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE
   } op_t;

   localparam int TW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT - 1) : '0;

   state_t        state, state_nxt;
   op_t           op_q, dec_op;
   logic [5:0]    dec_fmt;
   logic [2:0]    dec_rwm;
   logic          dec_a1, dec_a2;
   logic [TW-1:0] to_cnt;
   logic          wait_lo, to_hit;
   logic          unused_bits;

   assign unused_bits = &{1'b0, instr[31:7]};
   assign state_dbg   = state;

   // Opcode decode; only instr[6:0] determines legality and the datapath fields.
   always_comb begin
      dec_op  = OP_ILL;
      dec_fmt = 6'b000000;
      dec_rwm = 3'd0;
      dec_a1  = 1'b0;
      dec_a2  = 1'b0;
      case (instr[6:0])
         7'b0110111: begin dec_op = OP_LUI;    dec_fmt = 6'b010000; dec_rwm = 3'd3; dec_a2 = 1'b1; end
         7'b0010111: begin dec_op = OP_AUIPC;  dec_fmt = 6'b010000; dec_rwm = 3'd4; dec_a1 = 1'b1; dec_a2 = 1'b1; end
         7'b1101111: begin dec_op = OP_JAL;    dec_fmt = 6'b100000; dec_rwm = 3'd2; dec_a1 = 1'b1; dec_a2 = 1'b1; end
         7'b1100111: begin dec_op = OP_JALR;   dec_fmt = 6'b000010; dec_rwm = 3'd2; dec_a2 = 1'b1; end
         7'b1100011: begin dec_op = OP_BRANCH; dec_fmt = 6'b001000; end
         7'b0000011: begin dec_op = OP_LOAD;   dec_fmt = 6'b000010; dec_rwm = 3'd1; dec_a2 = 1'b1; end
         7'b0100011: begin dec_op = OP_STORE;  dec_fmt = 6'b000100; dec_a2 = 1'b1; end
         7'b0010011: begin dec_op = OP_IMM;    dec_fmt = 6'b000010; dec_a2 = 1'b1; end
         7'b0110011: begin dec_op = OP_REG;    dec_fmt = 6'b000001; end
         7'b0001111: begin dec_op = OP_FENCE;  dec_fmt = 6'b000010; dec_a2 = 1'b1; end
         default:    dec_op = OP_ILL;
      endcase
   end

   assign wait_lo = ((state == S_FETCH) && !imem_ready) || ((state == S_MEM) && !dmem_ready);
   assign to_hit  = (MEM_TIMEOUT != 0) && wait_lo && (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         op_q          <= OP_ILL;
         i_format      <= '0;
         reg_write_mux <= '0;
         alu_mux_1     <= 1'b0;
         alu2_mux      <= 1'b0;
         retired       <= '0;
         to_cnt        <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_DECODE) begin
            op_q          <= dec_op;
            i_format      <= dec_fmt;
            reg_write_mux <= dec_rwm;
            alu_mux_1     <= dec_a1;
            alu2_mux      <= dec_a2;
         end
         if (pc_write)
            retired <= retired + 1'b1;
         if ((MEM_TIMEOUT != 0) && wait_lo)
            to_cnt <= to_cnt + 1'b1;
         else
            to_cnt <= '0;
      end
   end

   always_comb begin
      state_nxt         = state;
      imem_req          = 1'b0;
      ir_write          = 1'b0;
      pc_write          = 1'b0;
      jump_mux          = 1'b0;
      branch_mux        = 1'b0;
      reg_write_enable  = 1'b0;
      dmem_read_enable  = 1'b0;
      dmem_write_enable = 1'b0;
      trap              = 1'b0;
      case (state)
         S_IDLE: state_nxt = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write  = 1'b1;
               state_nxt = S_DECODE;
            end else if (to_hit) begin
               state_nxt = S_TRAP;
            end
         end
         S_DECODE: state_nxt = (dec_op == OP_ILL) ? S_TRAP : S_EXEC;
         S_EXEC: begin
            case (op_q)
               OP_LOAD, OP_STORE: state_nxt = S_MEM;
               OP_BRANCH: begin
                  pc_write   = 1'b1;
                  branch_mux = branch_taken;
                  state_nxt  = S_FETCH;
               end
               OP_FENCE: begin
                  pc_write  = 1'b1;
                  state_nxt = S_FETCH;
               end
               default: state_nxt = S_WB;
            endcase
         end
         S_MEM: begin
            dmem_read_enable  = (op_q == OP_LOAD);
            dmem_write_enable = (op_q == OP_STORE);
            if (dmem_ready) begin
               // A store retires on its completing cycle; a load still needs writeback.
               pc_write  = (op_q == OP_STORE);
               state_nxt = (op_q == OP_STORE) ? S_FETCH : S_WB;
            end else if (to_hit) begin
               state_nxt = S_TRAP;
            end
         end
         S_WB: begin
            reg_write_enable = 1'b1;
            pc_write         = 1'b1;
            jump_mux         = (op_q == OP_JAL) || (op_q == OP_JALR);
            state_nxt        = S_FETCH;
         end
         S_TRAP: trap = 1'b1;
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
